// File: rtl/synth_pkg.sv
// Shared types and helpers for the music box sequencer and its tempo prescaler.
package synth_pkg;

    // Width of a tone half-period count (0 = silence)
    localparam int NOTE_W = 20;

    // Width of the tick counter; the longest note is 4<<7 = 512 ticks
    localparam int LEN_W = 10;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SOUND = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // A ROM word with both note and duration code zero terminates the song
    localparam logic [NOTE_W-1:0] END_NOTE = '0;
    localparam logic [2:0]        END_DUR  = 3'd0;

    // Duration code d -> note length in tempo ticks (4..512)
    function automatic logic [LEN_W-1:0] note_len(input logic [2:0] d);
        logic [LEN_W-1:0] base;
        base = LEN_W'(4);
        return base << d;
    endfunction

endpackage

// File: rtl/tempo_tick_gen.sv
// Tempo prescaler: counts 0..TICK_DIV-1 while enabled and ticks on the wrap.
// clear restarts the count at 0; dropping en freezes the count in place.
module tempo_tick_gen #(
    parameter int TICK_DIV = 1_562_500
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // The tick is a one-cycle strobe on the last count of each period
    assign tick = en && (cnt == CNT_W'(TICK_DIV - 1));

    // Prescaler register with clear priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/music_box_sequencer.sv
// Song sequencer: walks the song ROM one step at a time, times each note
// with the tempo prescaler and drives the tone generator, falling back to
// live keyboard notes while idle.
// Optional build macro KEY_OVERRIDE_EN: a held key overrides playback and
// pauses the note timing until it is released.
module music_box_sequencer
    import synth_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int TICK_DIV  = 1_562_500,
    parameter int GAP_TICKS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          song_sel,
    input  logic                start,
    input  logic                stop,
    input  logic [NOTE_W-1:0]   key_note,
    output logic [ADDR_W+1:0]   rom_addr,
    input  logic [NOTE_W-1:0]   rom_note,
    input  logic [2:0]          rom_dur,
    output logic [NOTE_W-1:0]   tone_count,
    output logic                play,
    output logic                busy,
    output logic [ADDR_W-1:0]   step,
    output logic                done
);

    localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    state_t             state_q, state_d;
    logic [1:0]         song_q, song_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [ADDR_W-1:0]  step_d, step_nxt;
    logic [ADDR_W+1:0]  rom_addr_d;
    logic [NOTE_W-1:0]  tone_d;
    logic               play_d, busy_d, done_d;
    logic               advance;
    logic               key_ovr, tick_en, tick_clear, tick;

`ifdef KEY_OVERRIDE_EN
    assign key_ovr = (state_q != S_IDLE) && (key_note != '0);
`else
    assign key_ovr = 1'b0;
`endif

    // Note timing runs only in SOUND/GAP and pauses under a key override
    assign tick_en    = ((state_q == S_SOUND) || (state_q == S_GAP)) && !key_ovr;
    assign tick_clear = (state_q == S_LOAD);
    assign step_nxt   = step + ADDR_W'(1);

    tempo_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .en    (tick_en),
        .tick  (tick)
    );

    // Next-state and next-output logic; every output is then registered
    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        note_d     = note_q;
        len_d      = len_q;
        tick_cnt_d = tick_cnt_q;
        step_d     = step;
        rom_addr_d = rom_addr;
        done_d     = 1'b0;
        advance    = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d    = S_FETCH;
            song_d     = song_sel;
            step_d     = '0;
            rom_addr_d = {song_sel, {ADDR_W{1'b0}}};
        end else if (!key_ovr) begin
            case (state_q)
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    note_d = rom_note;
                    if ((rom_note == END_NOTE) && (rom_dur == END_DUR)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        len_d      = note_len(rom_dur);
                        tick_cnt_d = '0;
                        state_d    = S_SOUND;
                    end
                end
                S_SOUND: begin
                    if (tick) begin
                        if (tick_cnt_q == len_q - LEN_W'(GAP_TICKS + 1)) begin
                            tick_cnt_d = '0;
                            if (GAP_TICKS == 0) begin
                                advance = 1'b1;
                            end else begin
                                state_d = S_GAP;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + LEN_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (tick_cnt_q == LEN_W'(GAP_LAST)) begin
                            tick_cnt_d = '0;
                            advance    = 1'b1;
                        end else begin
                            tick_cnt_d = tick_cnt_q + LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase

            // End of a step: either the song is exhausted or fetch the next one
            if (advance) begin
                if (step == {ADDR_W{1'b1}}) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    step_d     = step_nxt;
                    rom_addr_d = {song_q, step_nxt};
                    state_d    = S_FETCH;
                end
            end
        end

        if (state_d == S_IDLE) begin
            step_d = '0;
        end

        tone_d = '0;
        play_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                tone_d = key_note;
                play_d = (key_note != '0);
            end
            S_SOUND: begin
                tone_d = note_d;
                play_d = (note_d != '0);
            end
            default: ;
        endcase
        if (key_ovr) begin
            tone_d = key_note;
            play_d = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            song_q     <= '0;
            note_q     <= '0;
            len_q      <= '0;
            tick_cnt_q <= '0;
            step       <= '0;
            rom_addr   <= '0;
            tone_count <= '0;
            play       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            note_q     <= note_d;
            len_q      <= len_d;
            tick_cnt_q <= tick_cnt_d;
            step       <= step_d;
            rom_addr   <= rom_addr_d;
            tone_count <= tone_d;
            play       <= play_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_music_box_sequencer.sv
// Directed bench for music_box_sequencer with TICK_DIV=4 and GAP_TICKS=1.
// Optional build macro KEY_OVERRIDE_EN selects the key-override expectations.
module tb_music_box_sequencer;
    import synth_pkg::*;

    localparam int ADDR_W    = 6;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 1;

    localparam logic [NOTE_W-1:0] NOTE_A = 20'h2EA85;
    localparam logic [NOTE_W-1:0] NOTE_B = 20'h29919;
    localparam logic [NOTE_W-1:0] KEY_K  = 20'h1F47E;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          song_sel;
    logic                start;
    logic                stop;
    logic [NOTE_W-1:0]   key_note;
    logic [ADDR_W+1:0]   rom_addr;
    logic [NOTE_W-1:0]   rom_note;
    logic [2:0]          rom_dur;
    logic [NOTE_W-1:0]   tone_count;
    logic                play;
    logic                busy;
    logic [ADDR_W-1:0]   step;
    logic                done;

    logic [NOTE_W-1:0]   mem_note [0:255];
    logic [2:0]          mem_dur  [0:255];

    int n_cmp = 0;
    int n_err = 0;

    music_box_sequencer #(
        .ADDR_W    (ADDR_W),
        .TICK_DIV  (TICK_DIV),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .song_sel   (song_sel),
        .start      (start),
        .stop       (stop),
        .key_note   (key_note),
        .rom_addr   (rom_addr),
        .rom_note   (rom_note),
        .rom_dur    (rom_dur),
        .tone_count (tone_count),
        .play       (play),
        .busy       (busy),
        .step       (step),
        .done       (done)
    );

    // Clock
    always #5 clk = ~clk;

    // Synchronous song ROM: data valid one cycle after the address
    always @(posedge clk) begin
        rom_note <= mem_note[rom_addr];
        rom_dur  <= mem_dur[rom_addr];
    end

    // Advance n clock edges and land 1 time unit after the last one
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single-cycle start pulse; returns one cycle after the pulse
    task automatic pulse_start(input logic [1:0] sel);
        song_sel = sel;
        start    = 1'b1;
        cyc(1);
        start    = 1'b0;
    endtask

    task automatic load_roms();
        for (int a = 0; a < 256; a++) begin
            mem_note[a] = '0;
            mem_dur[a]  = 3'd0;
        end
        // song 1: two notes then end
        mem_note[8'h40] = NOTE_A; mem_dur[8'h40] = 3'd0;
        mem_note[8'h41] = NOTE_B; mem_dur[8'h41] = 3'd1;
        // song 2: one rest of d=2 then end
        mem_note[8'h80] = '0;     mem_dur[8'h80] = 3'd2;
        // song 3: 64 short notes, no end marker
        for (int k = 0; k < 64; k++) begin
            mem_note[8'hC0 + k] = NOTE_W'(32'h100 + k);
            mem_dur[8'hC0 + k]  = 3'd0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; key_note = '0; song_sel = 2'd0;
        cyc(2);
        n_cmp++; if (busy !== 1'b0 || play !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL reset_flags busy=%b play=%b done=%b want 0 0 0", busy, play, done); end
        n_cmp++; if (tone_count !== '0 || rom_addr !== '0 || step !== '0) begin
            n_err++; $display("FAIL reset_values tone=%h addr=%h step=%0d want 0", tone_count, rom_addr, step); end
        n_cmp++; if (dut.state_q !== S_IDLE) begin
            n_err++; $display("FAIL reset_state got=%0d want IDLE", dut.state_q); end
        rst = 1'b0;
        cyc(2);
        pulse_start(2'd1);
        cyc(4);
        n_cmp++; if (play !== 1'b1 || tone_count !== NOTE_A) begin
            n_err++; $display("FAIL pre_reset_sound play=%b tone=%h want 1 %h", play, tone_count, NOTE_A); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tone_count !== '0 || play !== 1'b0 || busy !== 1'b0 || rom_addr !== '0 || step !== '0) begin
            n_err++; $display("FAIL async_reset tone=%h play=%b busy=%b addr=%h step=%0d want all 0",
                              tone_count, play, busy, rom_addr, step); end
        n_cmp++; if (dut.state_q !== S_IDLE) begin
            n_err++; $display("FAIL async_reset_state got=%0d want IDLE", dut.state_q); end
        cyc(1);
        rst = 1'b0;
        cyc(3);
        n_cmp++; if (busy !== 1'b0 || play !== 1'b0 || dut.state_q !== S_IDLE) begin
            n_err++; $display("FAIL post_reset_idle busy=%b play=%b state=%0d want 0 0 IDLE", busy, play, dut.state_q); end
    endtask

    task automatic test_idle_key();
        key_note = 20'h12345;
        n_cmp++; if (tone_count !== '0) begin
            n_err++; $display("FAIL idle_key_latency tone=%h want 0", tone_count); end
        cyc(1);
        n_cmp++; if (tone_count !== 20'h12345 || play !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL idle_key tone=%h play=%b busy=%b want 12345 1 0", tone_count, play, busy); end
        key_note = '0;
        cyc(1);
        n_cmp++; if (tone_count !== '0 || play !== 1'b0) begin
            n_err++; $display("FAIL idle_key_release tone=%h play=%b want 0 0", tone_count, play); end
    endtask

    task automatic test_song_timing();
        logic [NOTE_W-1:0] exp_tone;
        logic exp_play, exp_busy, exp_done;
        pulse_start(2'd1);
        n_cmp++; if (rom_addr !== 8'h40 || dut.state_q !== S_FETCH) begin
            n_err++; $display("FAIL song1_fetch addr=%h state=%0d want 40 FETCH", rom_addr, dut.state_q); end
        for (int i = 1; i <= 56; i++) begin
            exp_tone = '0;
            if (i >= 3 && i <= 14) exp_tone = NOTE_A;
            if (i >= 21 && i <= 48) exp_tone = NOTE_B;
            exp_play = (exp_tone != '0);
            exp_busy = (i <= 54);
            exp_done = (i == 55);
            n_cmp++; if (tone_count !== exp_tone || play !== exp_play) begin
                n_err++; $display("FAIL song1_tone cyc=%0d tone=%h play=%b want %h %b", i, tone_count, play, exp_tone, exp_play); end
            n_cmp++; if (busy !== exp_busy || done !== exp_done) begin
                n_err++; $display("FAIL song1_flags cyc=%0d busy=%b done=%b want %b %b", i, busy, done, exp_busy, exp_done); end
            if (i < 56) cyc(1);
        end
    endtask

    task automatic test_rest();
        logic exp_busy, exp_done;
        pulse_start(2'd2);
        for (int i = 1; i <= 70; i++) begin
            exp_busy = (i <= 68);
            exp_done = (i == 69);
            n_cmp++; if (tone_count !== '0 || play !== 1'b0) begin
                n_err++; $display("FAIL rest_tone cyc=%0d tone=%h play=%b want 0 0", i, tone_count, play); end
            n_cmp++; if (busy !== exp_busy || done !== exp_done) begin
                n_err++; $display("FAIL rest_flags cyc=%0d busy=%b done=%b want %b %b", i, busy, done, exp_busy, exp_done); end
            if (i < 70) cyc(1);
        end
    endtask

    task automatic test_full_song();
        logic [NOTE_W-1:0] exp_tone;
        logic [ADDR_W-1:0] exp_step;
        logic [ADDR_W+1:0] exp_addr;
        logic exp_busy, exp_done;
        int p, k, r;
        pulse_start(2'd3);
        for (int i = 1; i <= 1154; i++) begin
            exp_tone = '0;
            if (i >= 3 && i <= 1152) begin
                p = i - 3;
                k = p / 18;
                r = p % 18;
                if (r < 12) exp_tone = NOTE_W'(32'h100 + k);
            end
            if (i >= 1153)   exp_step = '0;
            else if (i < 3)  exp_step = '0;
            else             exp_step = ADDR_W'((i - 1) / 18);
            exp_addr = (i >= 1153) ? 8'hFF : (8'hC0 | {2'b00, exp_step});
            exp_busy = (i <= 1152);
            exp_done = (i == 1153);
            n_cmp++; if (tone_count !== exp_tone || play !== (exp_tone != '0)) begin
                n_err++; $display("FAIL full_tone cyc=%0d tone=%h play=%b want %h", i, tone_count, play, exp_tone); end
            n_cmp++; if (step !== exp_step || rom_addr !== exp_addr) begin
                n_err++; $display("FAIL full_step cyc=%0d step=%0d addr=%h want %0d %h", i, step, rom_addr, exp_step, exp_addr); end
            n_cmp++; if (busy !== exp_busy || done !== exp_done) begin
                n_err++; $display("FAIL full_flags cyc=%0d busy=%b done=%b want %b %b", i, busy, done, exp_busy, exp_done); end
            if (i < 1154) cyc(1);
        end
    endtask

    task automatic test_back_to_back();
        // stop and start together: stop wins
        pulse_start(2'd1);
        cyc(4);
        song_sel = 2'd2; stop = 1'b1; start = 1'b1;
        cyc(1);
        stop = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || play !== 1'b0 || dut.state_q !== S_IDLE) begin
                n_err++; $display("FAIL stop_start cyc=%0d busy=%b done=%b play=%b want 0 0 0", i, busy, done, play); end
            cyc(1);
        end
        // later start alone
        pulse_start(2'd2);
        n_cmp++; if (rom_addr !== 8'h80 || busy !== 1'b1 || dut.state_q !== S_FETCH) begin
            n_err++; $display("FAIL start_alone addr=%h busy=%b want 80 1", rom_addr, busy); end
        // restart while busy with a new song
        cyc(5);
        pulse_start(2'd1);
        n_cmp++; if (rom_addr !== 8'h40 || step !== '0 || dut.state_q !== S_FETCH) begin
            n_err++; $display("FAIL restart addr=%h step=%0d want 40 0", rom_addr, step); end
        cyc(2);
        n_cmp++; if (tone_count !== NOTE_A || play !== 1'b1) begin
            n_err++; $display("FAIL restart_tone tone=%h play=%b want %h 1", tone_count, play, NOTE_A); end
        // start in the same cycle as the end-marker LOAD: no done
        stop = 1'b1; cyc(1); stop = 1'b0;
        pulse_start(2'd1);
        cyc(53);
        song_sel = 2'd2; start = 1'b1;
        cyc(1);
        start = 1'b0;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b1 || rom_addr !== 8'h80) begin
            n_err++; $display("FAIL start_beats_end done=%b busy=%b addr=%h want 0 1 80", done, busy, rom_addr); end
        stop = 1'b1; cyc(1); stop = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL final_stop busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_key_override();
        pulse_start(2'd1);
        cyc(4);
        key_note = KEY_K;
        cyc(1);
`ifdef KEY_OVERRIDE_EN
        n_cmp++; if (tone_count !== KEY_K || play !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL ovr_start tone=%h play=%b busy=%b want %h 1 1", tone_count, play, busy, KEY_K); end
        cyc(9);
        n_cmp++; if (tone_count !== KEY_K || play !== 1'b1) begin
            n_err++; $display("FAIL ovr_hold tone=%h play=%b want %h 1", tone_count, play, KEY_K); end
        key_note = '0;
        cyc(1);
        n_cmp++; if (tone_count !== NOTE_A || play !== 1'b1) begin
            n_err++; $display("FAIL ovr_resume tone=%h play=%b want %h 1", tone_count, play, NOTE_A); end
        cyc(8);
        n_cmp++; if (tone_count !== NOTE_A || play !== 1'b1) begin
            n_err++; $display("FAIL ovr_note_end tone=%h play=%b want %h 1", tone_count, play, NOTE_A); end
        cyc(1);
        n_cmp++; if (tone_count !== '0 || play !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL ovr_gap tone=%h play=%b busy=%b want 0 0 1", tone_count, play, busy); end
`else
        n_cmp++; if (tone_count !== NOTE_A || play !== 1'b1) begin
            n_err++; $display("FAIL key_ignored tone=%h play=%b want %h 1", tone_count, play, NOTE_A); end
        cyc(8);
        n_cmp++; if (tone_count !== NOTE_A || play !== 1'b1) begin
            n_err++; $display("FAIL key_ignored_end tone=%h play=%b want %h 1", tone_count, play, NOTE_A); end
        cyc(1);
        n_cmp++; if (tone_count !== '0 || play !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL key_ignored_gap tone=%h play=%b busy=%b want 0 0 1", tone_count, play, busy); end
        key_note = '0;
`endif
        stop = 1'b1; cyc(1); stop = 1'b0;
        cyc(1);
    endtask

    initial begin
        load_roms();
        test_reset();
        test_idle_key();
        test_song_timing();
        test_rest();
        test_full_song();
        test_back_to_back();
        test_key_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
